// File: rtl/rock_generator.sv
// Triangular cradle rocking generator: turns latched amplitude/frequency into a
// symmetric swing about centre 128, with a PWM drive proportional to position.
module rock_generator #(
    parameter int unsigned TICK_DIV = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] A,
    input  logic [3:0] F,
    output logic [7:0] pos,
    output logic       pwm,
    output logic       dir,
    output logic       busy,
    output logic       period_done
);

    localparam int unsigned PRESC_W = 16;
    localparam int unsigned POS_W   = 8;
    localparam int unsigned CALC_W  = 9;
    localparam int unsigned CENTRE  = 128;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RISE,
        S_FALL,
        S_RETURN
    } state_t;

    state_t              r_state;
    logic [PRESC_W-1:0]  r_presc;
    logic [POS_W-1:0]    r_pwm_cnt;
    logic [3:0]          r_a_l;
    logic [3:0]          r_f_l;
    logic [POS_W-1:0]    r_pos;
    logic                r_pwm;
    logic                r_dir;
    logic                r_busy;
    logic                r_period_done;

    logic                w_tick;
    logic                w_run;
    logic [CALC_W-1:0]   w_amp;
    logic [CALC_W-1:0]   w_hi;
    logic [CALC_W-1:0]   w_lo;
    logic [CALC_W-1:0]   w_pos;
    logic [CALC_W-1:0]   w_step;
    logic [CALC_W-1:0]   w_up;
    logic [CALC_W-1:0]   w_dn;
    logic [CALC_W-1:0]   w_dn_lim;

    assign w_tick   = (r_presc == PRESC_W'(TICK_DIV - 1));
    assign w_run    = (A != 4'd0) && (F != 4'd0);
    assign w_amp    = CALC_W'({r_a_l, 3'b000});
    assign w_hi     = CALC_W'(CENTRE) + w_amp;
    assign w_lo     = CALC_W'(CENTRE) - w_amp;
    assign w_pos    = CALC_W'(r_pos);
    assign w_step   = CALC_W'(r_f_l);
    assign w_up     = w_pos + w_step;
    // Falling clamp compared as pos <= lo+F so the subtraction never underflows.
    assign w_dn_lim = w_lo + w_step;
    assign w_dn     = w_pos - w_step;

    assign pos         = r_pos;
    assign pwm         = r_pwm;
    assign dir         = r_dir;
    assign busy        = r_busy;
    assign period_done = r_period_done;

    // Position-update prescaler.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PRESC_W'(1);
        end
    end

    // Free-running PWM; a new pos applies at the current count, not at a period boundary.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pwm_cnt <= '0;
            r_pwm     <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + POS_W'(1);
            r_pwm     <= (r_pwm_cnt < r_pos);
        end
    end

    // Swing FSM; A/F are only latched while idle or at the centre crossing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_a_l         <= 4'd0;
            r_f_l         <= 4'd0;
            r_pos         <= POS_W'(CENTRE);
            r_dir         <= 1'b0;
            r_busy        <= 1'b0;
            r_period_done <= 1'b0;
        end else begin
            r_period_done <= 1'b0;
            if (w_tick) begin
                case (r_state)
                    S_IDLE: begin
                        r_a_l <= A;
                        r_f_l <= F;
                        if (w_run) begin
                            r_state <= S_RISE;
                            r_dir   <= 1'b1;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_RISE: begin
                        if (w_up >= w_hi) begin
                            r_pos   <= POS_W'(w_hi);
                            r_state <= S_FALL;
                            r_dir   <= 1'b0;
                        end else begin
                            r_pos <= POS_W'(w_up);
                        end
                    end
                    S_FALL: begin
                        if (w_pos <= w_dn_lim) begin
                            r_pos   <= POS_W'(w_lo);
                            r_state <= S_RETURN;
                            r_dir   <= 1'b1;
                        end else begin
                            r_pos <= POS_W'(w_dn);
                        end
                    end
                    S_RETURN: begin
                        if (w_up >= CALC_W'(CENTRE)) begin
                            r_pos         <= POS_W'(CENTRE);
                            r_period_done <= 1'b1;
                            r_a_l         <= A;
                            r_f_l         <= F;
                            if (w_run) begin
                                r_state <= S_RISE;
                                r_dir   <= 1'b1;
                                r_busy  <= 1'b1;
                            end else begin
                                r_state <= S_IDLE;
                                r_dir   <= 1'b0;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_pos <= POS_W'(w_up);
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_dir   <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
